// File: rtl/uds_tile_feeder.sv
// Tile feeder for the up/down-sampling engine: walks a row-major feature map in SRAM,
// assembles A-element tiles and issues the idata_valid strobe plus the active window.
`timescale 1ns/1ps
module uds_tile_feeder #(
  parameter int A           = 64,
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int ADDR_W      = 12,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cfg_scale_factor,
  input  logic [1:0]        cfg_function_mode,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              hold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [255:0]      mem_rdata,
  output logic [A*32-1:0]   idata,
  output logic              idata_valid,
  output logic              active,
  output logic [1:0]        scale_factor,
  output logic [1:0]        function_mode,
  output logic              busy,
  output logic              done
);

  localparam int TR      = A / 8;
  localparam int WPR     = IMG_W / 8;
  localparam int TILES_Y = IMG_H / TR;
  localparam int DATA_W  = A * 32;

  localparam logic [ADDR_W-1:0] TR_A   = ADDR_W'(TR);
  localparam logic [ADDR_W-1:0] WPR_A  = ADDR_W'(WPR);
  localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(WPR - 1);
  localparam logic [ADDR_W-1:0] LAST_Y = ADDR_W'(TILES_Y - 1);
  localparam logic [31:0]       TR_C      = 32'(TR);
  localparam logic [31:0]       HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0]       GAP_LAST  = 32'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_HOLD,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   tile_x_q, tile_x_d;
  logic [ADDR_W-1:0]   tile_y_q, tile_y_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [1:0]          sf_q, sf_d;
  logic [1:0]          fm_q, fm_d;
  logic [DATA_W-1:0]   idata_q, idata_d;
  logic                done_q, done_d;
  logic                last_tile;
  logic [ADDR_W-1:0]   rd_addr;

  // Address arithmetic deliberately wraps at ADDR_W bits.
  always_comb begin
    rd_addr   = base_q + (tile_y_q * TR_A + ADDR_W'(cnt_q)) * WPR_A + tile_x_q;
    last_tile = (tile_x_q == LAST_X) && (tile_y_q == LAST_Y);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tile_x_d = tile_x_q;
    tile_y_d = tile_y_q;
    base_d   = base_q;
    sf_d     = sf_q;
    fm_d     = fm_q;
    idata_d  = idata_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          sf_d     = cfg_scale_factor;
          fm_d     = cfg_function_mode;
          base_d   = cfg_base;
          tile_x_d = '0;
          tile_y_d = '0;
          cnt_d    = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        for (int unsigned r = 0; r < TR; r++) begin
          if (cnt_q == 32'(r + 1)) idata_d[r*256 +: 256] = mem_rdata;
        end
        if (cnt_q == TR_C) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SEND: begin
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q < GAP_LAST) begin
          cnt_d = cnt_q + 32'd1;
        end else if (last_tile) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (!hold) begin
          cnt_d   = '0;
          state_d = S_LOAD;
          if (tile_x_q == LAST_X) begin
            tile_x_d = '0;
            tile_y_d = tile_y_q + ADDR_W'(1);
          end else begin
            tile_x_d = tile_x_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tile_x_q <= '0;
      tile_y_q <= '0;
      base_q   <= '0;
      sf_q     <= '0;
      fm_q     <= '0;
      idata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tile_x_q <= tile_x_d;
      tile_y_q <= tile_y_d;
      base_q   <= base_d;
      sf_q     <= sf_d;
      fm_q     <= fm_d;
      idata_q  <= idata_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    mem_rd_en     = (state_q == S_LOAD) && (cnt_q < TR_C);
    mem_addr      = mem_rd_en ? rd_addr : '0;
    idata         = idata_q;
    idata_valid   = (state_q == S_SEND);
    active        = (state_q == S_HOLD);
    scale_factor  = sf_q;
    function_mode = fm_q;
    busy          = (state_q != S_IDLE);
    done          = done_q;
  end

endmodule
